lector_contador: RTL and testbench
==================================

Name: lector_contador

Overview:
- Requesting side of the change-counter readout handshake.
- Polls a bank of NUM_CH change counters in order. For each counter it sends a one-cycle req with that counter's idx bit, waits for that counter's valid_cont, then captures its data_cont.
- Each captured count is presented as a single result beat. A per-channel timeout flags counters that never answer.
- Sits between the counter bank and the test/stat logic that consumes per-FIFO change counts.

Parameters:
- BUFFER_DEPTH, 8, width of each counter value (data_cont / cont width on the counter side).
- NUM_CH, 4, number of counters polled per sweep.
- CH_WIDTH, 2, width of channel number, ≥ clog2(NUM_CH).
- TIMEOUT, 7, max WAIT cycles per channel before it is abandoned (1..255).

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, begin one sweep of all channels; sampled only in IDLE.
- req, output, 1, request strobe, broadcast to all counters.
- idx, output, NUM_CH, one-hot counter select; bit i drives idx of counter i.
- valid_cont, input, NUM_CH, bit i = valid_cont of counter i.
- data_cont, input, NUM_CH*BUFFER_DEPTH, packed counts; counter i at bits [i*BUFFER_DEPTH +: BUFFER_DEPTH].
- result_valid, output, 1, one-cycle pulse: result_data/result_ch are valid.
- result_data, output, BUFFER_DEPTH, captured count.
- result_ch, output, CH_WIDTH, channel the count came from.
- busy, output, 1, high while a sweep is in progress.
- done, output, 1, one-cycle pulse at sweep end.
- timeout_err, output, NUM_CH, sticky per-channel no-response flags; cleared on accepted start.

Behaviour:
- Reset (sync, checked first every edge, including mid-sweep):
  - Outputs: req=0, idx=0, result_valid=0, result_data=0, result_ch=0, busy=0, done=0, timeout_err=0.
  - Internal: state=IDLE, ch=0, wait counter=0.
  - Reset mid-sweep drops req/idx at the next edge; no result or done is produced.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - busy=0.
  - start=1 → next state REQ, ch=0, timeout_err cleared to 0, busy=1.
- REQ (exactly one cycle):
  - req=1, idx=(1<<ch).
  - Next state WAIT; wait counter=0.
  - req/idx are 0 in every other state.
- WAIT:
  - Sample only valid_cont[ch]; other bits are ignored.
  - The counter refreshes data_cont on the edge that sees req; any stale valid_cont from before REQ is therefore harmless. The first WAIT cycle already carries fresh data.
  - valid_cont[ch]=1 → next cycle:
    - result_valid=1, result_data=data_cont slice ch, result_ch=ch.
    - Go to next channel.
  - Else, if the wait counter reaches TIMEOUT-1 → set timeout_err[ch]=1, no result_valid, go to next channel. Else increment the wait counter.
- Next channel:
  - ch<NUM_CH-1 → ch+1, state REQ.
  - Otherwise → IDLE, done=1 and busy=0 in the same cycle.
  - A result_valid for the last channel coincides with done.
- Throughput with immediate responses: 2 cycles/channel; start-to-done = 2*NUM_CH+1 cycles.
- start while busy is ignored; start held high re-triggers one cycle after done.
- result_data is held between pulses; result_valid and done are single-cycle.
- No arithmetic on data; count width passes through unchanged. ch never exceeds NUM_CH-1.

Test Plan:
- Reset, then start pulse; all counters assert valid the cycle after their req, with data_cont = {8'h04, 8'h03, 8'h02, 8'h01} (counter 3 … counter 0):
  - req high at cycles 1, 3, 5, 7 with idx 0001, 0010, 0100, 1000.
  - result pulses ch0=01, ch1=02, ch2=03, ch3=04.
  - done at cycle 9, timeout_err=0000.
- Counter 2 response delayed 3 cycles → ch2 result arrives 3 cycles later, values still correct, no timeout.
- Counter 1 never asserts valid (TIMEOUT=7):
  - After 7 WAIT cycles, timeout_err=0010; no ch1 result.
  - ch2 and ch3 still read; done asserted.
  - The next start clears timeout_err.
- valid_cont held high on all channels before start (stale) → still exactly one req per channel, results equal data_cont present after each req.
- start pulsed again mid-sweep → ignored, single done. start held high → back-to-back sweeps.
- reset asserted during WAIT of ch1 → next cycle: req=0, idx=0, busy=0, no result_valid/done; a fresh start restarts from ch0.

Source files
------------

// File: rtl/lector_contador.sv
// Polls NUM_CH change counters in turn and emits each captured count as a one-beat result.
// Latency: 2 cycles per answering channel; start-to-done is 2*NUM_CH+1 cycles with immediate answers.
// No backpressure: result beats are pulses, and a silent channel is abandoned after TIMEOUT wait cycles.
module lector_contador #(
  parameter int BUFFER_DEPTH = 8,
  parameter int NUM_CH       = 4,
  parameter int CH_WIDTH     = 2,
  parameter int TIMEOUT      = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic                           req,
  output logic [NUM_CH-1:0]              idx,
  input  logic [NUM_CH-1:0]              valid_cont,
  input  logic [NUM_CH*BUFFER_DEPTH-1:0] data_cont,
  output logic                           result_valid,
  output logic [BUFFER_DEPTH-1:0]        result_data,
  output logic [CH_WIDTH-1:0]            result_ch,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_CH-1:0]              timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [CH_WIDTH-1:0] LAST_CH   = CH_WIDTH'(NUM_CH - 1);
  localparam logic [7:0]          WAIT_LAST = 8'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [CH_WIDTH-1:0]     ch_q, ch_d;
  logic [7:0]              wcnt_q, wcnt_d;
  logic                    advance;

  logic                    req_d;
  logic [NUM_CH-1:0]       idx_d;
  logic                    result_valid_d;
  logic [BUFFER_DEPTH-1:0] result_data_d;
  logic [CH_WIDTH-1:0]     result_ch_d;
  logic                    busy_d;
  logic                    done_d;
  logic [NUM_CH-1:0]       timeout_err_d;

  // Next-state and next-output logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    wcnt_d         = wcnt_q;
    advance        = 1'b0;
    result_valid_d = 1'b0;
    result_data_d  = result_data;
    result_ch_d    = result_ch;
    done_d         = 1'b0;
    timeout_err_d  = timeout_err;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = REQ;
          ch_d          = '0;
          timeout_err_d = '0;
        end
      end
      REQ: begin
        state_d = WAIT;
        wcnt_d  = '0;
      end
      WAIT: begin
        // The counter refreshes its data on the edge that saw req, so the first WAIT cycle is already fresh.
        if (valid_cont[ch_q]) begin
          result_valid_d = 1'b1;
          result_data_d  = data_cont[int'(ch_q)*BUFFER_DEPTH +: BUFFER_DEPTH];
          result_ch_d    = ch_q;
          advance        = 1'b1;
        end else if (wcnt_q == WAIT_LAST) begin
          timeout_err_d[ch_q] = 1'b1;
          advance             = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      if (ch_q == LAST_CH) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        ch_d    = ch_q + 1'b1;
        state_d = REQ;
      end
    end

    req_d  = (state_d == REQ);
    idx_d  = req_d ? (NUM_CH'(1) << ch_d) : '0;
    busy_d = (state_d != IDLE);
  end

  // State register; reset wins over everything, including a sweep in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      req          <= 1'b0;
      idx          <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_ch    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= '0;
    end else begin
      req          <= req_d;
      idx          <= idx_d;
      result_valid <= result_valid_d;
      result_data  <= result_data_d;
      result_ch    <= result_ch_d;
      busy         <= busy_d;
      done         <= done_d;
      timeout_err  <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_lector_contador.sv
// Directed bench for lector_contador with a behavioural counter bank.
// Cycle 1 is the cycle right after the edge that accepts start.
// Outputs are sampled on the falling edge.
module tb_lector_contador;

  localparam int BD = 8;
  localparam int NC = 4;
  localparam int CW = 2;
  localparam int TO = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             req;
  logic [NC-1:0]    idx;
  logic [NC-1:0]    valid_cont;
  logic [NC*BD-1:0] data_cont;
  logic             result_valid;
  logic [BD-1:0]    result_data;
  logic [CW-1:0]    result_ch;
  logic             busy;
  logic             done;
  logic [NC-1:0]    timeout_err;

  int total = 0;
  int bad   = 0;

  // counter bank configuration
  int dly[NC];
  bit never_ans[NC];
  bit stale;
  int rem[NC];

  // per-cycle record of a sweep
  logic          r_req[0:31];
  logic [NC-1:0] r_idx[0:31];
  logic          r_rv[0:31];
  logic [CW-1:0] r_rch[0:31];
  logic [BD-1:0] r_rdat[0:31];
  logic          r_done[0:31];
  logic          r_busy[0:31];
  logic [NC-1:0] r_terr[0:31];

  lector_contador #(
    .BUFFER_DEPTH(BD), .NUM_CH(NC), .CH_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .req(req), .idx(idx),
    .valid_cont(valid_cont), .data_cont(data_cont),
    .result_valid(result_valid), .result_data(result_data), .result_ch(result_ch),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Counter bank: a counter that saw req answers dly cycles after the cycle following req.
  initial begin
    logic [NC-1:0] seen;
    logic [NC-1:0] v;
    valid_cont = '0;
    for (int i = 0; i < NC; i++) rem[i] = -1;
    forever begin
      @(negedge clk);
      seen = req ? idx : '0;
      @(posedge clk);
      #1;
      v = '0;
      for (int i = 0; i < NC; i++) begin
        if (rem[i] > 0) rem[i] = rem[i] - 1;
        else if (rem[i] == 0) rem[i] = -1;
        if (seen[i] && !never_ans[i]) rem[i] = dly[i];
        v[i] = (rem[i] == 0);
      end
      valid_cont = v | {NC{stale}};
    end
  end

  task automatic quiet();
    repeat (40) @(posedge clk);
  endtask

  // Pulses start, then records ncyc cycles; start is raised again in cycle mid_start, or every cycle if hold.
  task automatic capture(input int ncyc, input int mid_start, input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start     = hold || (c == mid_start);
      r_req[c]  = req;
      r_idx[c]  = idx;
      r_rv[c]   = result_valid;
      r_rch[c]  = result_ch;
      r_rdat[c] = result_data;
      r_done[c] = done;
      r_busy[c] = busy;
      r_terr[c] = timeout_err;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b want 0", req); end
    total++; if (idx !== 4'b0000) begin bad++; $display("FAIL reset_idx: got %b want 0000", idx); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_rv: got %0b want 0", result_valid); end
    total++; if (result_data !== 8'h00) begin bad++; $display("FAIL reset_rdat: got %h want 00", result_data); end
    total++; if (result_ch !== 2'd0) begin bad++; $display("FAIL reset_rch: got %0d want 0", result_ch); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
    total++; if (timeout_err !== 4'b0000) begin bad++; $display("FAIL reset_terr: got %b want 0000", timeout_err); end
    start = 1'b0;
    reset = 1'b0;
    quiet();
  endtask

  task automatic test_basic();
    int req_at[NC];
    int res_at[NC];
    logic          e_req;
    logic [NC-1:0] e_idx;
    logic          e_rv;
    logic [CW-1:0] e_ch;
    logic [BD-1:0] e_dat;
    req_at = '{1, 3, 5, 7};
    res_at = '{3, 5, 7, 9};
    capture(10, 0, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      e_req = 1'b0; e_idx = '0; e_rv = 1'b0; e_ch = '0; e_dat = '0;
      for (int k = 0; k < NC; k++) begin
        if (req_at[k] == c) begin e_req = 1'b1; e_idx = NC'(1) << k; end
        if (res_at[k] == c) begin e_rv = 1'b1; e_ch = CW'(k); e_dat = BD'(k + 1); end
      end
      total++; if (r_req[c] !== e_req || r_idx[c] !== e_idx) begin bad++;
        $display("FAIL basic_req c=%0d: got req=%0b idx=%b want req=%0b idx=%b", c, r_req[c], r_idx[c], e_req, e_idx); end
      total++; if (r_rv[c] !== e_rv) begin bad++;
        $display("FAIL basic_rv c=%0d: got %0b want %0b", c, r_rv[c], e_rv); end
      if (e_rv) begin
        total++; if (r_rch[c] !== e_ch || r_rdat[c] !== e_dat) begin bad++;
          $display("FAIL basic_res c=%0d: got ch=%0d dat=%h want ch=%0d dat=%h", c, r_rch[c], r_rdat[c], e_ch, e_dat); end
      end
      total++; if (r_done[c] !== (c == 9)) begin bad++;
        $display("FAIL basic_done c=%0d: got %0b want %0b", c, r_done[c], (c == 9)); end
      total++; if (r_busy[c] !== (c <= 8)) begin bad++;
        $display("FAIL basic_busy c=%0d: got %0b want %0b", c, r_busy[c], (c <= 8)); end
    end
    total++; if (r_terr[9] !== 4'b0000) begin bad++; $display("FAIL basic_terr: got %b want 0000", r_terr[9]); end
    quiet();
  endtask

  task automatic test_delay();
    int req_at[NC];
    int res_at[NC];
    logic          e_req;
    logic [NC-1:0] e_idx;
    logic          e_rv;
    logic [CW-1:0] e_ch;
    logic [BD-1:0] e_dat;
    req_at = '{1, 3, 5, 10};
    res_at = '{3, 5, 10, 12};
    dly[2] = 3;
    capture(13, 0, 1'b0);
    dly[2] = 0;
    for (int c = 1; c <= 13; c++) begin
      e_req = 1'b0; e_idx = '0; e_rv = 1'b0; e_ch = '0; e_dat = '0;
      for (int k = 0; k < NC; k++) begin
        if (req_at[k] == c) begin e_req = 1'b1; e_idx = NC'(1) << k; end
        if (res_at[k] == c) begin e_rv = 1'b1; e_ch = CW'(k); e_dat = BD'(k + 1); end
      end
      total++; if (r_req[c] !== e_req || r_idx[c] !== e_idx) begin bad++;
        $display("FAIL delay_req c=%0d: got req=%0b idx=%b want req=%0b idx=%b", c, r_req[c], r_idx[c], e_req, e_idx); end
      total++; if (r_rv[c] !== e_rv) begin bad++;
        $display("FAIL delay_rv c=%0d: got %0b want %0b", c, r_rv[c], e_rv); end
      if (e_rv) begin
        total++; if (r_rch[c] !== e_ch || r_rdat[c] !== e_dat) begin bad++;
          $display("FAIL delay_res c=%0d: got ch=%0d dat=%h want ch=%0d dat=%h", c, r_rch[c], r_rdat[c], e_ch, e_dat); end
      end
      total++; if (r_done[c] !== (c == 12)) begin bad++;
        $display("FAIL delay_done c=%0d: got %0b want %0b", c, r_done[c], (c == 12)); end
    end
    total++; if (r_terr[12] !== 4'b0000) begin bad++; $display("FAIL delay_terr: got %b want 0000", r_terr[12]); end
    quiet();
  endtask

  task automatic test_timeout();
    int req_at[NC];
    int res_at[NC];
    logic          e_req;
    logic [NC-1:0] e_idx;
    logic          e_rv;
    logic [CW-1:0] e_ch;
    logic [BD-1:0] e_dat;
    req_at = '{1, 3, 11, 13};
    res_at = '{3, -1, 13, 15};
    never_ans[1] = 1'b1;
    capture(16, 0, 1'b0);
    never_ans[1] = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      e_req = 1'b0; e_idx = '0; e_rv = 1'b0; e_ch = '0; e_dat = '0;
      for (int k = 0; k < NC; k++) begin
        if (req_at[k] == c) begin e_req = 1'b1; e_idx = NC'(1) << k; end
        if (res_at[k] == c) begin e_rv = 1'b1; e_ch = CW'(k); e_dat = BD'(k + 1); end
      end
      total++; if (r_req[c] !== e_req || r_idx[c] !== e_idx) begin bad++;
        $display("FAIL tmo_req c=%0d: got req=%0b idx=%b want req=%0b idx=%b", c, r_req[c], r_idx[c], e_req, e_idx); end
      total++; if (r_rv[c] !== e_rv) begin bad++;
        $display("FAIL tmo_rv c=%0d: got %0b want %0b", c, r_rv[c], e_rv); end
      if (e_rv) begin
        total++; if (r_rch[c] !== e_ch || r_rdat[c] !== e_dat) begin bad++;
          $display("FAIL tmo_res c=%0d: got ch=%0d dat=%h want ch=%0d dat=%h", c, r_rch[c], r_rdat[c], e_ch, e_dat); end
      end
      total++; if (r_done[c] !== (c == 15)) begin bad++;
        $display("FAIL tmo_done c=%0d: got %0b want %0b", c, r_done[c], (c == 15)); end
    end
    total++; if (r_terr[10] !== 4'b0000) begin bad++; $display("FAIL tmo_terr_early: got %b want 0000", r_terr[10]); end
    total++; if (r_terr[11] !== 4'b0010) begin bad++; $display("FAIL tmo_terr_set: got %b want 0010", r_terr[11]); end
    total++; if (r_terr[15] !== 4'b0010) begin bad++; $display("FAIL tmo_terr_end: got %b want 0010", r_terr[15]); end
    quiet();
  endtask

  task automatic test_clear();
    @(negedge clk);
    total++; if (timeout_err !== 4'b0010) begin bad++; $display("FAIL clear_sticky: got %b want 0010", timeout_err); end
    capture(10, 0, 1'b0);
    total++; if (r_terr[1] !== 4'b0000) begin bad++; $display("FAIL clear_on_start: got %b want 0000", r_terr[1]); end
    total++; if (r_terr[9] !== 4'b0000) begin bad++; $display("FAIL clear_end: got %b want 0000", r_terr[9]); end
    total++; if (r_done[9] !== 1'b1) begin bad++; $display("FAIL clear_done: got %0b want 1", r_done[9]); end
    quiet();
  endtask

  task automatic test_stale();
    int            nreq;
    logic [BD-1:0] e_dat[NC];
    e_dat = '{8'ha1, 8'hb2, 8'hc3, 8'hd4};
    data_cont = 32'hd4c3b2a1;
    stale = 1'b1;
    repeat (3) @(posedge clk);
    capture(10, 0, 1'b0);
    stale = 1'b0;
    nreq = 0;
    for (int c = 1; c <= 10; c++) if (r_req[c] === 1'b1) nreq++;
    total++; if (nreq != 4) begin bad++; $display("FAIL stale_nreq: got %0d want 4", nreq); end
    for (int k = 0; k < NC; k++) begin
      total++; if (r_req[2*k+1] !== 1'b1 || r_idx[2*k+1] !== (NC'(1) << k)) begin bad++;
        $display("FAIL stale_req k=%0d: got req=%0b idx=%b", k, r_req[2*k+1], r_idx[2*k+1]); end
      total++; if (r_rv[2*k+3] !== 1'b1 || r_rch[2*k+3] !== CW'(k) || r_rdat[2*k+3] !== e_dat[k]) begin bad++;
        $display("FAIL stale_res k=%0d: got rv=%0b ch=%0d dat=%h want rv=1 ch=%0d dat=%h",
                 k, r_rv[2*k+3], r_rch[2*k+3], r_rdat[2*k+3], k, e_dat[k]); end
    end
    total++; if (r_done[9] !== 1'b1) begin bad++; $display("FAIL stale_done: got %0b want 1", r_done[9]); end
    data_cont = 32'h04030201;
    quiet();
  endtask

  task automatic test_back_to_back();
    int ndone;
    int nreq;
    int nres;
    // start pulsed again in cycle 4, mid-sweep
    capture(12, 4, 1'b0);
    ndone = 0; nreq = 0;
    for (int c = 1; c <= 12; c++) begin
      if (r_done[c] === 1'b1) ndone++;
      if (r_req[c] === 1'b1) nreq++;
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL mid_ndone: got %0d want 1", ndone); end
    total++; if (nreq != 4) begin bad++; $display("FAIL mid_nreq: got %0d want 4", nreq); end
    total++; if (r_req[5] !== 1'b1 || r_idx[5] !== 4'b0100) begin bad++;
      $display("FAIL mid_req5: got req=%0b idx=%b want req=1 idx=0100", r_req[5], r_idx[5]); end
    total++; if (r_done[9] !== 1'b1) begin bad++; $display("FAIL mid_done9: got %0b want 1", r_done[9]); end
    quiet();
    // start held high: second sweep begins the cycle after done
    capture(18, 0, 1'b1);
    total++; if (r_done[9] !== 1'b1 || r_done[18] !== 1'b1) begin bad++;
      $display("FAIL b2b_done: got c9=%0b c18=%0b want 1 1", r_done[9], r_done[18]); end
    total++; if (r_req[10] !== 1'b1 || r_idx[10] !== 4'b0001) begin bad++;
      $display("FAIL b2b_req10: got req=%0b idx=%b want req=1 idx=0001", r_req[10], r_idx[10]); end
    total++; if (r_busy[10] !== 1'b1) begin bad++; $display("FAIL b2b_busy10: got %0b want 1", r_busy[10]); end
    nres = 0;
    for (int c = 1; c <= 18; c++) if (r_rv[c] === 1'b1) nres++;
    total++; if (nres != 8) begin bad++; $display("FAIL b2b_nres: got %0d want 8", nres); end
    total++; if (r_rv[18] !== 1'b1 || r_rch[18] !== 2'd3 || r_rdat[18] !== 8'h04) begin bad++;
      $display("FAIL b2b_last: got rv=%0b ch=%0d dat=%h want rv=1 ch=3 dat=04", r_rv[18], r_rch[18], r_rdat[18]); end
    quiet();
  endtask

  task automatic test_reset_mid();
    never_ans[1] = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before: got %0b want 1", busy); end
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if (req !== 1'b0 || idx !== 4'b0000) begin bad++;
        $display("FAIL rmid_req c=%0d: got req=%0b idx=%b want 0 0000", c, req, idx); end
      total++; if (busy !== 1'b0 || result_valid !== 1'b0 || done !== 1'b0) begin bad++;
        $display("FAIL rmid_flags c=%0d: got busy=%0b rv=%0b done=%0b want 0 0 0", c, busy, result_valid, done); end
    end
    reset = 1'b0;
    never_ans[1] = 1'b0;
    repeat (2) @(posedge clk);
    capture(4, 0, 1'b0);
    total++; if (r_req[1] !== 1'b1 || r_idx[1] !== 4'b0001) begin bad++;
      $display("FAIL rmid_restart_req: got req=%0b idx=%b want 1 0001", r_req[1], r_idx[1]); end
    total++; if (r_rv[3] !== 1'b1 || r_rch[3] !== 2'd0 || r_rdat[3] !== 8'h01) begin bad++;
      $display("FAIL rmid_restart_res: got rv=%0b ch=%0d dat=%h want 1 0 01", r_rv[3], r_rch[3], r_rdat[3]); end
    quiet();
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    data_cont = 32'h04030201;
    stale     = 1'b0;
    for (int i = 0; i < NC; i++) begin
      dly[i]       = 0;
      never_ans[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_delay();
    test_timeout();
    test_clear();
    test_stale();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
